frame_buffer_writer: RTL and testbench
======================================

// Module: frame_buffer_writer
// PURPOSE
//   Upstream feeder for led_matrix_controller. Accepts an RGB888 pixel stream (valid/ready + start-of-frame).
//   Writes each frame into the back bank of a two-bank pixel RAM (bank bit = address MSB).
//   Swaps the display bank only on the controller's end-of-frame pulse, so the panel never shows a torn frame.
// PARAMETERS
//   MATRIX_COLS   64    panel columns
//   MATRIX_ROWS   32    panel rows
//   DATA_WIDTH    24    pixel width, {R[23:16],G[15:8],B[7:0]}
//   ADDR_WIDTH    $clog2(MATRIX_COLS*MATRIX_ROWS) (11)   per-bank address width; localparam PIXELS = COLS*ROWS
// PORTS
//   i_clk         in   1               system clock, all logic on posedge
//   rst           in   1               asynchronous active-high reset
//   s_valid       in   1               input pixel valid
//   s_ready       out  1               block can accept a pixel
//   s_sof         in   1               qualifies s_data as pixel 0 of a frame (row-major, col fastest)
//   s_data        in   DATA_WIDTH      input pixel
//   o_wr_en       out  1               RAM write strobe
//   o_wr_addr     out  ADDR_WIDTH+1    {bank, pixel index}; bank is always ~o_rd_bank
//   o_wr_data     out  DATA_WIDTH      RAM write data
//   i_frame_done  in   1               1-cycle pulse from controller after the last row of a displayed frame
//   o_rd_bank     out  1               bank the controller reads; drives its read-address MSB
//   o_sync_err    out  1               1-cycle pulse: pixel dropped or frame restarted early
// BEHAVIOUR
//   Reset (async assert, sync release): s_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rd_bank=0, o_sync_err=0, cnt=0, state=IDLE.
//   Handshake (hs) = s_valid & s_ready. All outputs registered.
//   Write latency: o_wr_en/addr/data valid 1 cycle after hs (2 cycles with FB_GAMMA_EN). One write per hs, no gaps added.
//   FSM:
//     IDLE   : s_ready=1.
//              hs & s_sof -> write index 0, cnt=1, go WRITE.
//              hs & ~s_sof -> pixel discarded, o_sync_err pulse.
//     WRITE  : s_ready=1.
//              hs & ~s_sof -> write index cnt, cnt++.
//              hs & s_sof -> resync: write index 0, cnt=1, o_sync_err pulse; back bank is not swapped.
//              hs on index PIXELS-1 -> go WAIT_SWAP, cnt=0.
//     WAIT_SWAP: s_ready=0. Swap condition: i_frame_done=1 AND write pipeline empty (no pending o_wr_en).
//              On the swap condition, o_rd_bank toggles next cycle, then go IDLE.
//   i_frame_done is ignored outside WAIT_SWAP, including the cycle the last pixel is accepted; the swap then waits for the next pulse.
//   A frame with PIXELS=1 goes IDLE->WAIT_SWAP directly.
//   cnt is ADDR_WIDTH+1 bits wide; no wrap beyond PIXELS-1 is permitted.
//   Reset mid-frame: partial frame abandoned; o_rd_bank returns to 0; back bank contents undefined.
// CONFIGURATION
//   FB_GAMMA_EN defined: each 8-bit channel is replaced by (c*c)>>8 through a registered LUT-free multiply stage.
//     Write latency = 2. Examples: 255->254, 128->64, 16->1, 0->0.
//   FB_GAMMA_EN undefined: data passes unchanged; write latency = 1.
// STRUCTURE
//   fb_pkg:
//     typedef enum logic [1:0] {FB_IDLE, FB_WRITE, FB_WAIT_SWAP} fb_state_t
//     typedef struct packed {logic [7:0] r,g,b;} rgb888_t
//     function fb_gamma8()
//   Sub-module fb_gamma_stage: 1-cycle registered per-channel square, instantiated only under FB_GAMMA_EN.
// TESTING
//   1. Reset, then stream 2048 px (data=index, sof on px0), i_frame_done pulse 10 cycles later
//      -> 2048 writes at {1,idx} data=idx; o_rd_bank 0->1; s_ready=0 until swap.
//   2. 3 px with s_sof=0 in IDLE -> 3 o_sync_err pulses, no o_wr_en; then sof frame writes from index 0.
//   3. sof asserted at px 100 mid-frame -> o_sync_err pulse, write at index 0, frame completes 2048 px after it, single swap.
//   4. i_frame_done on the same cycle as the last-pixel hs -> no swap; next pulse toggles o_rd_bank.
//   5. s_valid toggled 50% random over 2 frames -> writes contiguous 0..2047 into bank 1 then bank 0, o_rd_bank ends at 0.
//   6. FB_GAMMA_EN: px 0x80FF10 -> o_wr_data 0x40FE01 exactly 2 cycles after hs; async rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and the gamma helper for the frame buffer writer.
package fb_pkg;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_WRITE,
        FB_WAIT_SWAP
    } fb_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Square-law gamma: (c*c)>>8, so 255 maps to 254 and 16 maps to 1.
    function automatic logic [7:0] fb_gamma8(input logic [7:0] c);
        logic [15:0] sq;
        sq = 16'(c) * 16'(c);
        return sq[15:8];
    endfunction

endpackage

// File: rtl/fb_if.sv
// Pixel stream into the frame buffer writer: valid/ready handshake plus start-of-frame.
interface fb_if #(
    parameter int unsigned DATA_WIDTH = 24
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic                  s_sof;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (
        output s_valid,
        output s_sof,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_sof,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/fb_gamma_stage.sv
// One registered stage that squares each RGB channel of a pending RAM write.
// Only compiled when FB_GAMMA_EN is defined.
`ifdef FB_GAMMA_EN
module fb_gamma_stage
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic [ADDR_BITS-1:0] pix_addr,
    input  logic [23:0]          pix_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [23:0]          wr_data
);

    rgb888_t px_in;
    rgb888_t px_sq;

    always_comb begin
        px_in   = pix_data;
        px_sq.r = fb_gamma8(px_in.r);
        px_sq.g = fb_gamma8(px_in.g);
        px_sq.b = fb_gamma8(px_in.b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pix_en;
            if (pix_en) begin
                wr_addr <= pix_addr;
                wr_data <= px_sq;
            end
        end
    end

endmodule
`endif

// File: rtl/frame_buffer_writer.sv
// Writes an RGB888 pixel stream into the back bank of a two-bank pixel RAM and swaps banks
// only on the controller's end-of-frame pulse. FB_GAMMA_EN adds a squaring stage (latency 2).
module frame_buffer_writer
    import fb_pkg::*;
#(
    parameter int unsigned MATRIX_COLS = 64,
    parameter int unsigned MATRIX_ROWS = 32,
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH  = $clog2(MATRIX_COLS * MATRIX_ROWS)
) (
    input  logic                  i_clk,
    input  logic                  rst,
    fb_if.slave                   pix,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH:0]   o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_frame_done,
    output logic                  o_rd_bank,
    output logic                  o_sync_err
);

    localparam int unsigned PIXELS = MATRIX_COLS * MATRIX_ROWS;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

    fb_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  sync_err_q, sync_err_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  wr1_en_q, wr1_en_d;
    logic [ADDR_WIDTH:0]   wr1_addr_q, wr1_addr_d;
    logic [DATA_WIDTH-1:0] wr1_data_q, wr1_data_d;

    logic                  hs;
    logic                  write;
    logic [CNT_W-1:0]      idx;
    logic                  pipe_busy;

    assign hs = pix.s_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sync_err_d = 1'b0;
        rd_bank_d  = rd_bank_q;
        write      = 1'b0;
        idx        = cnt_q;

        unique case (state_q)
            FB_IDLE: begin
                if (hs) begin
                    if (pix.s_sof) begin
                        write = 1'b1;
                        idx   = '0;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            FB_WRITE: begin
                if (hs) begin
                    write = 1'b1;
                    // An early sof restarts the frame in the same back bank.
                    if (pix.s_sof) begin
                        idx        = '0;
                        sync_err_d = 1'b1;
                    end
                end
            end
            FB_WAIT_SWAP: begin
                if (i_frame_done && !pipe_busy) begin
                    rd_bank_d = ~rd_bank_q;
                    state_d   = FB_IDLE;
                end
            end
            default: state_d = FB_IDLE;
        endcase

        if (write) begin
            if (idx == LAST_IDX) begin
                state_d = FB_WAIT_SWAP;
                cnt_d   = '0;
            end else begin
                state_d = FB_WRITE;
                cnt_d   = idx + 1'b1;
            end
        end

        ready_d    = (state_d != FB_WAIT_SWAP);
        wr1_en_d   = write;
        wr1_addr_d = {~rd_bank_q, idx[ADDR_WIDTH-1:0]};
        wr1_data_d = pix.s_data;
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q    <= FB_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            sync_err_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr1_en_q   <= 1'b0;
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            sync_err_q <= sync_err_d;
            rd_bank_q  <= rd_bank_d;
            wr1_en_q   <= wr1_en_d;
            if (wr1_en_d) begin
                wr1_addr_q <= wr1_addr_d;
                wr1_data_q <= wr1_data_d;
            end
        end
    end

    assign pix.s_ready = ready_q;
    assign o_rd_bank   = rd_bank_q;
    assign o_sync_err  = sync_err_q;

`ifdef FB_GAMMA_EN
    fb_gamma_stage #(
        .ADDR_BITS (CNT_W)
    ) u_gamma (
        .clk      (i_clk),
        .rst      (rst),
        .pix_en   (wr1_en_q),
        .pix_addr (wr1_addr_q),
        .pix_data (wr1_data_q),
        .wr_en    (o_wr_en),
        .wr_addr  (o_wr_addr),
        .wr_data  (o_wr_data)
    );

    // Swapping is held off until both stages have flushed into the back bank.
    assign pipe_busy = wr1_en_q | o_wr_en;
`else
    assign o_wr_en   = wr1_en_q;
    assign o_wr_addr = wr1_addr_q;
    assign o_wr_data = wr1_data_q;
    assign pipe_busy = wr1_en_q;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized bench for frame_buffer_writer against a frame-level reference model.
module tb_frame_buffer_writer;

    localparam int PIXELS = 2048;
`ifdef FB_GAMMA_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [23:0] wr_data;
    logic        rd_bank;
    logic        sync_err;

    fb_if #(.DATA_WIDTH(24)) pix_bus ();

    frame_buffer_writer dut (
        .i_clk        (clk),
        .rst          (rst),
        .pix          (pix_bus),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .i_frame_done (frame_done),
        .o_rd_bank    (rd_bank),
        .o_sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks frame progress, display bank and expected RAM writes.
    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [23:0] data;
    } wr_t;

    wr_t wq[$];
    bit  m_ready   = 1'b0;
    bit  m_err     = 1'b0;
    bit  m_waiting = 1'b0;
    bit  m_active  = 1'b0;
    bit  m_bank    = 1'b0;
    int  m_idx     = 0;
    int  m_last_hs = 0;
    int  cyc       = 0;

    function automatic logic [23:0] model_pix(input logic [23:0] d);
`ifdef FB_GAMMA_EN
        int r = int'(d[23:16]);
        int g = int'(d[15:8]);
        int b = int'(d[7:0]);
        return {8'((r * r) / 256), 8'((g * g) / 256), 8'((b * b) / 256)};
`else
        return d;
`endif
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            wq.delete();
            m_ready   = 1'b0;
            m_err     = 1'b0;
            m_waiting = 1'b0;
            m_active  = 1'b0;
            m_bank    = 1'b0;
            m_idx     = 0;
        end else begin
            check_eq("s_ready", 32'(pix_bus.s_ready), 32'(m_ready));
            check_eq("sync_err", 32'(sync_err), 32'(m_err));
            check_eq("rd_bank", 32'(rd_bank), 32'(m_bank));
            if (wq.size() != 0 && wq[0].due == cyc) begin
                check_eq("wr_en", 32'(wr_en), 32'd1);
                check_eq("wr_addr", 32'(wr_addr), 32'(wq[0].addr));
                check_eq("wr_data", 32'(wr_data), 32'(wq[0].data));
                void'(wq.pop_front());
            end else begin
                check_eq("wr_en_idle", 32'(wr_en), 32'd0);
            end

            m_err = 1'b0;
            if (m_waiting) begin
                if (frame_done && cyc > m_last_hs + LAT) begin
                    m_bank    = !m_bank;
                    m_waiting = 1'b0;
                end
            end else if (pix_bus.s_valid && m_ready) begin
                m_last_hs = cyc;
                if (pix_bus.s_sof) begin
                    m_err    = m_active;
                    m_idx    = 0;
                    m_active = 1'b1;
                end else if (!m_active) begin
                    m_err = 1'b1;
                end
                if (m_active) begin
                    wq.push_back('{due: cyc + LAT, addr: {~m_bank, 11'(m_idx)},
                                   data: model_pix(pix_bus.s_data)});
                    m_idx++;
                    if (m_idx == PIXELS) begin
                        m_active  = 1'b0;
                        m_waiting = 1'b1;
                    end
                end
            end
            m_ready = !m_waiting;
        end
    end

    // Offers one pixel until it is accepted; valid is randomly withheld at (100-prob)%.
    task automatic push_px(input bit sof, input logic [23:0] d, input int prob, input bit fd);
        bit done = 1'b0;
        int tries = 0;
        pix_bus.s_sof  = sof;
        pix_bus.s_data = d;
        while (!done && tries < 200) begin
            pix_bus.s_valid = ($urandom_range(99) < 32'(prob));
            frame_done = fd && pix_bus.s_valid;
            @(negedge clk);
            done = pix_bus.s_valid && pix_bus.s_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        pix_bus.s_valid = 1'b0;
        frame_done      = 1'b0;
        check_eq("hs_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic send_frame(input int prob);
        for (int i = 0; i < PIXELS; i++) begin
            push_px(i == 0, 24'($urandom), prob, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        pix_bus.s_valid = 1'b0;
        pix_bus.s_sof   = 1'b0;
        pix_bus.s_data  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(pix_bus.s_ready), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("rst_sync_err", 32'(sync_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Full frame with data = index, swap pulse 10 cycles later.
        for (int i = 0; i < PIXELS; i++) push_px(i == 0, 24'(i), 100, 1'b0);
        idle(10);
        pulse_done();
        idle(3);
        check_eq("t1_bank", 32'(rd_bank), 32'd1);

        // Stray pixels in IDLE, then a clean frame starting with a known colour.
        for (int i = 0; i < 3; i++) push_px(1'b0, 24'($urandom), 100, 1'b0);
        for (int i = 0; i < PIXELS; i++)
            push_px(i == 0, (i == 0) ? 24'h80FF10 : 24'($urandom), 100, 1'b0);
        idle(4);
        pulse_done();
        idle(3);
        check_eq("t2_bank", 32'(rd_bank), 32'd0);

        // Early sof at pixel 100 restarts the frame.
        for (int i = 0; i < 100; i++) push_px(i == 0, 24'($urandom), 100, 1'b0);
        send_frame(100);
        idle(4);
        pulse_done();
        idle(3);
        check_eq("t3_bank", 32'(rd_bank), 32'd1);

        // Asynchronous reset mid-frame with a write in flight.
        for (int i = 0; i < 500; i++) push_px(i == 0, 24'($urandom), 100, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("mid_rst_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("mid_rst_ready", 32'(pix_bus.s_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Two frames with random valid gaps: bank 1 then bank 0.
        send_frame(50);
        idle(3);
        pulse_done();
        idle(3);
        check_eq("t5_bank_a", 32'(rd_bank), 32'd1);
        send_frame(50);
        idle(3);
        pulse_done();
        idle(3);
        check_eq("t5_bank_b", 32'(rd_bank), 32'd0);

        // frame_done coinciding with the last handshake must not swap.
        for (int i = 0; i < PIXELS; i++)
            push_px(i == 0, 24'($urandom), 100, i == PIXELS - 1);
        idle(5);
        check_eq("t4_no_swap", 32'(rd_bank), 32'd0);
        check_eq("t4_ready_low", 32'(pix_bus.s_ready), 32'd0);
        pulse_done();
        idle(3);
        check_eq("t4_swap", 32'(rd_bank), 32'd1);
        check_eq("t4_pending", 32'(wq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
